// File: rtl/z88_slot_ctrl.sv
// Memory-slot controller: decodes a slot from the top address bits and runs a
// timed CE/OE/WE strobe sequence with per-slot wait states, returning a one-cycle ack.
module z88_slot_ctrl #(
    parameter int unsigned              NUM_SLOTS = 4,
    parameter int unsigned              SEL_W     = 2,
    parameter int unsigned              ADDR_W    = 22,
    parameter int unsigned              DATA_W    = 8,
    parameter logic [4*NUM_SLOTS-1:0]   WAIT_CYC  = 16'h0000,
    parameter logic [NUM_SLOTS-1:0]     WR_MASK   = 4'b1110
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    output logic                          ack,
    output logic                          err,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADDR_W-SEL_W-1:0]       mem_a,
    output logic [DATA_W-1:0]             mem_do,
    input  logic [NUM_SLOTS*DATA_W-1:0]   mem_di,
    output logic [NUM_SLOTS-1:0]          mem_ce_n,
    output logic                          mem_oe_n,
    output logic                          mem_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_SETUP,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_SLOTS-1:0]      sel_q, sel_d;
    logic                      we_q, we_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [ADDR_W-SEL_W-1:0]   mem_a_q, mem_a_d;
    logic [DATA_W-1:0]         mem_do_q, mem_do_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [NUM_SLOTS-1:0]      ce_n_q, ce_n_d;
    logic                      oe_n_q, oe_n_d;
    logic                      we_n_q, we_n_d;

    logic [SEL_W-1:0]          req_slot;
    logic [NUM_SLOTS-1:0]      sel_req;
    logic                      slot_ok;
    logic                      slot_wr;
    logic [3:0]                wait_req;
    logic [DATA_W-1:0]         rd_mux;

    assign req_slot = addr[ADDR_W-1 -: SEL_W];

    // Slot decode kept one-hot; an index past NUM_SLOTS simply matches nothing.
    always_comb begin
        sel_req  = '0;
        slot_ok  = 1'b0;
        slot_wr  = 1'b0;
        wait_req = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (req_slot == SEL_W'(i)) begin
                sel_req[i] = 1'b1;
                slot_ok    = 1'b1;
                slot_wr    = WR_MASK[i];
                wait_req   = WAIT_CYC[4*i +: 4];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | mem_di[DATA_W*i +: DATA_W];
            end
        end
    end

    // Output registers are loaded with the values of the state being entered,
    // so every strobe is a flop output with no input-to-output path.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        mem_a_d  = mem_a_q;
        mem_do_d = mem_do_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        ce_n_d   = '1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!slot_ok || (we && !slot_wr)) begin
                        state_d = S_ERR;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = S_SETUP;
                        sel_d    = sel_req;
                        we_d     = we;
                        cnt_d    = wait_req;
                        mem_a_d  = addr[ADDR_W-SEL_W-1:0];
                        mem_do_d = wdata;
                        ce_n_d   = ~sel_req;
                        oe_n_d   = we;
                    end
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                ce_n_d  = ~sel_q;
                oe_n_d  = we_q;
                we_n_d  = ~we_q;
            end
            S_ACCESS: begin
                ce_n_d = ~sel_q;
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = rd_mux;
                    end
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    oe_n_d = we_q;
                    we_n_d = ~we_q;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            mem_a_q  <= '0;
            mem_do_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ce_n_q   <= '1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            mem_a_q  <= mem_a_d;
            mem_do_q <= mem_do_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_do   = mem_do_q;
    assign mem_ce_n = ce_n_q;
    assign mem_oe_n = oe_n_q;
    assign mem_we_n = we_n_q;

endmodule

// File: tb/tb_z88_slot_ctrl.sv
// Bench for z88_slot_ctrl: transaction-timeline model checked every cycle,
// plus directed transactions with hand-computed widths, latencies and data.
module tb_z88_slot_ctrl;

    localparam logic [15:0] WAITS = 16'hF420;   // slot3=15, slot2=4, slot1=2, slot0=0
    localparam logic [3:0]  WRM   = 4'b1110;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [21:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        ack, err;
    logic [7:0]  rdata, mem_do;
    logic [19:0] mem_a;
    logic [31:0] mem_di = {8'h3C, 8'h96, 8'h11, 8'hA5};
    logic [3:0]  mem_ce_n;
    logic        mem_oe_n, mem_we_n;

    logic        req2 = 1'b0;
    logic        ack2, err2, oe2, we2;
    logic [7:0]  rdata2, do2;
    logic [19:0] a2;
    logic [23:0] mem_di2 = 24'h332211;
    logic [2:0]  ce2;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    z88_slot_ctrl #(.NUM_SLOTS(4), .SEL_W(2), .ADDR_W(22), .DATA_W(8),
                    .WAIT_CYC(WAITS), .WR_MASK(WRM)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .mem_a(mem_a), .mem_do(mem_do),
        .mem_di(mem_di), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n));

    z88_slot_ctrl #(.NUM_SLOTS(3), .SEL_W(2), .ADDR_W(22), .DATA_W(8),
                    .WAIT_CYC(12'h000), .WR_MASK(3'b110)) dut3 (
        .clk(clk), .reset_n(reset_n), .req(req2), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack2), .err(err2), .rdata(rdata2), .mem_a(a2), .mem_do(do2),
        .mem_di(mem_di2), .mem_ce_n(ce2), .mem_oe_n(oe2), .mem_we_n(we2));

    // Model: an accepted request expands into a per-cycle timeline of outputs.
    typedef struct packed {
        logic       ack;
        logic       err;
        logic [3:0] ce;
        logic       oe;
        logic       wen;
        logic       ld;
    } ent_t;

    localparam ent_t IDLE_E = '{ack: 1'b0, err: 1'b0, ce: 4'hF, oe: 1'b1, wen: 1'b1, ld: 1'b0};

    ent_t        tl[$];
    logic        e_ack = 1'b0, e_err = 1'b0, e_oe = 1'b1, e_wen = 1'b1;
    logic [3:0]  e_ce = 4'hF;
    logic [7:0]  e_rdata = '0, e_do = '0;
    logic [19:0] e_a = '0;
    int          m_slot = 0;

    always @(posedge clk or negedge reset_n) begin
        ent_t e;
        int   s, w;
        if (!reset_n) begin
            tl.delete();
            e_ack <= 1'b0; e_err <= 1'b0; e_ce <= 4'hF; e_oe <= 1'b1; e_wen <= 1'b1;
            e_rdata <= '0; e_a <= '0; e_do <= '0;
        end else begin
            if (tl.size() == 0 && req) begin
                s = int'(addr[21:20]);
                w = int'(WAITS[4*s +: 4]);
                if (we && !WRM[s]) begin
                    tl.push_back('{ack: 1'b1, err: 1'b1, ce: 4'hF, oe: 1'b1, wen: 1'b1, ld: 1'b0});
                end else begin
                    m_slot = s;
                    e_a  <= addr[19:0];
                    e_do <= wdata;
                    for (int k = 0; k <= w + 2; k++) begin
                        e.ack = (k == w + 2);
                        e.err = 1'b0;
                        e.ce  = ~(4'b0001 << s);
                        e.oe  = !(!we && k <= w + 1);
                        e.wen = !(we && k >= 1 && k <= w + 1);
                        e.ld  = (k == w + 2) && !we;
                        tl.push_back(e);
                    end
                end
                tl.push_back(IDLE_E);
            end
            if (tl.size() != 0) e = tl.pop_front();
            else                e = IDLE_E;
            e_ack <= e.ack; e_err <= e.err; e_ce <= e.ce; e_oe <= e.oe; e_wen <= e.wen;
            if (e.ld) e_rdata <= mem_di[8*m_slot +: 8];
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if ({ack, err, mem_ce_n, mem_oe_n, mem_we_n, rdata, mem_a, mem_do} !==
                {e_ack, e_err, e_ce, e_oe, e_wen, e_rdata, e_a, e_do}) begin
                failures++;
                $display("FAIL cycle_model t=%0t got ack=%b err=%b ce=%b oe=%b we=%b rd=%h a=%h do=%h want ack=%b err=%b ce=%b oe=%b we=%b rd=%h a=%h do=%h",
                         $time, ack, err, mem_ce_n, mem_oe_n, mem_we_n, rdata, mem_a, mem_do,
                         e_ack, e_err, e_ce, e_oe, e_wen, e_rdata, e_a, e_do);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic w, input logic [21:0] a, input logic [7:0] d,
                           output int lat, output int ce_cnt, output int oe_cnt,
                           output int we_cnt, output logic [3:0] ce_pat,
                           output logic err_seen, output logic [19:0] a_seen,
                           output logic [7:0] do_seen);
        bit got = 1'b0;
        lat = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
        ce_pat = 4'hF; err_seen = 1'b0; a_seen = '0; do_seen = '0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (mem_ce_n != 4'hF) begin
                ce_cnt++;
                ce_pat  = mem_ce_n;
                a_seen  = mem_a;
                do_seen = mem_do;
            end
            if (!mem_oe_n) oe_cnt++;
            if (!mem_we_n) we_cnt++;
            if (ack) begin
                err_seen = err;
                req = 1'b0;
                got = 1'b1;
                break;
            end
        end
        chk("ack_timeout", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int lat, cc, oc, wc, gap, acks;
        logic [3:0]  pat;
        logic        es;
        logic [19:0] as;
        logic [7:0]  ds;
        bit          seen_first, seen_second_ce, ok;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce", 32'(mem_ce_n), 32'hF);
        chk("rst_strobes", {29'd0, ack, mem_oe_n, mem_we_n}, 32'h3);
        chk("rst_data", {4'd0, rdata, mem_a}, 32'h0);
        reset_n = 1'b1;
        cmp_on  = 1'b1;

        // Read slot 0, W=0
        run_txn(1'b0, 22'h000123, 8'h00, lat, cc, oc, wc, pat, es, as, ds);
        chk("rd0_lat", 32'(lat), 32'd3);
        chk("rd0_ce_w", 32'(cc), 32'd3);
        chk("rd0_oe_w", 32'(oc), 32'd2);
        chk("rd0_we_w", 32'(wc), 32'd0);
        chk("rd0_ce_pat", 32'(pat), 32'hE);
        chk("rd0_mem_a", 32'(as), 32'h00123);
        chk("rd0_err", 32'(es), 32'd0);
        chk("rd0_rdata", 32'(rdata), 32'hA5);

        // Write slot 1, W=2
        run_txn(1'b1, 22'h100040, 8'h5A, lat, cc, oc, wc, pat, es, as, ds);
        chk("wr1_lat", 32'(lat), 32'd5);
        chk("wr1_ce_w", 32'(cc), 32'd5);
        chk("wr1_we_w", 32'(wc), 32'd3);
        chk("wr1_oe_w", 32'(oc), 32'd0);
        chk("wr1_ce_pat", 32'(pat), 32'hD);
        chk("wr1_mem_do", 32'(ds), 32'h5A);
        chk("wr1_rdata_kept", 32'(rdata), 32'hA5);

        // Write to read-only slot 0
        run_txn(1'b1, 22'h000010, 8'hFF, lat, cc, oc, wc, pat, es, as, ds);
        chk("wrro_lat", 32'(lat), 32'd1);
        chk("wrro_err", 32'(es), 32'd1);
        chk("wrro_strobes", 32'(cc + oc + wc), 32'd0);
        chk("wrro_rdata_kept", 32'(rdata), 32'hA5);

        // Back-to-back reads, slot 2 (W=4) then slot 3 (W=15), req held high
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 22'h2ABCDE;
        gap = 0; acks = 0; cc = 0; seen_first = 1'b0; seen_second_ce = 1'b0;
        for (int i = 0; i < 60 && acks < 2; i++) begin
            @(negedge clk);
            if (seen_first && mem_ce_n == 4'hF && !seen_second_ce) gap++;
            if (seen_first && mem_ce_n != 4'hF) begin
                seen_second_ce = 1'b1;
                cc++;
            end
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    chk("b2b_rdata1", 32'(rdata), 32'h96);
                    seen_first = 1'b1;
                    addr = 22'h3FFFFF;
                end else begin
                    chk("b2b_rdata2", 32'(rdata), 32'h3C);
                    req = 1'b0;
                end
            end
        end
        chk("b2b_acks", 32'(acks), 32'd2);
        chk("b2b_gap", 32'(gap), 32'd1);
        chk("w15_ce_w", 32'(cc), 32'd18);
        @(negedge clk);

        // Asynchronous reset during ACCESS of a W=4 write to slot 2
        req = 1'b1; we = 1'b1; addr = 22'h200777; wdata = 8'hC3;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (!mem_we_n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_access", 32'(ok), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_ce", 32'(mem_ce_n), 32'hF);
        chk("rst_mid_we_ack", {30'd0, mem_we_n, ack}, 32'h2);
        chk("rst_mid_rdata", 32'(rdata), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        run_txn(1'b0, 22'h1000FF, 8'h00, lat, cc, oc, wc, pat, es, as, ds);
        chk("post_rst_lat", 32'(lat), 32'd5);
        chk("post_rst_rdata", 32'(rdata), 32'h11);
        chk("post_rst_mem_a", 32'(as), 32'h000FF);

        // Three-slot instance: slot index 3 does not exist
        @(negedge clk);
        req2 = 1'b1; we = 1'b0; addr = 22'h300000;
        ok = 1'b1;
        @(negedge clk);
        chk("ns3_ack_err", {30'd0, ack2, err2}, 32'h3);
        req2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ce2 != 3'b111 || !oe2 || !we2) ok = 1'b0;
            @(negedge clk);
        end
        chk("ns3_no_strobes", 32'(ok), 32'd1);
        chk("ns3_ack_single", 32'(ack2), 32'd0);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z88_slot_ctrl.md
Name: z88_slot_ctrl

Overview:
Parameterised memory-slot controller between the Blink-side bus and NUM_SLOTS asynchronous memory slots (internal ROM, internal RAM, card slots).
- Decodes the slot from the top address bits.
- Sequences chip-enable, output-enable and write-enable with a per-slot programmable wait-state count.
- Registers read data and returns a single-cycle acknowledge.
- Replaces the fixed combinational ROM/RAM enable and data-mux glue at the top level with a timed, generalised slot bus.

Parameters:
- NUM_SLOTS, 4, number of slots; legal range 1..2**SEL_W.
- SEL_W, 2, number of top address bits used as the slot index.
- ADDR_W, 22, width of the host address.
- DATA_W, 8, data width.
- WAIT_CYC, 16'h0000, packed 4 bits per slot; slot i uses WAIT_CYC[4i+3:4i] = extra strobe cycles W (0..15).
- WR_MASK, 4'b1110, bit i = 1 means slot i is writable.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  host request, level-sensitive; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  host address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- ack  out  1  one-cycle transaction-complete pulse.
- err  out  1  one-cycle pulse coincident with ack on a rejected request.
- rdata  out  DATA_W  registered read data; valid from the ack cycle until the next read ack.
- mem_a  out  ADDR_W-SEL_W  slot-local address.
- mem_do  out  DATA_W  write data to memories.
- mem_di  in  NUM_SLOTS*DATA_W  packed read data; slot i occupies [DATA_W*i +: DATA_W].
- mem_ce_n  out  NUM_SLOTS  per-slot chip enable, active low.
- mem_oe_n  out  1  shared output enable, active low.
- mem_we_n  out  1  shared write enable, active low.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-transaction):
  - State IDLE; ack = 0, err = 0.
  - rdata = 0, mem_a = 0, mem_do = 0.
  - mem_ce_n all 1, mem_oe_n = 1, mem_we_n = 1.
- All outputs are registered; no combinational path from any input to any output.
- Latched on acceptance: slot = addr[ADDR_W-1 -: SEL_W], mem_a = addr[ADDR_W-SEL_W-1:0], mem_do = wdata, we, W = the accepted slot's wait count.
- States:
  - IDLE: ack = 0. On req = 1:
    - slot >= NUM_SLOTS, or we = 1 with WR_MASK[slot] = 0 -> ERR.
    - Otherwise -> SETUP.
  - ERR (1 cycle): ack = 1, err = 1, no strobes asserted -> IDLE.
  - SETUP (1 cycle): mem_ce_n[slot] = 0; mem_oe_n = 0 if read; mem_we_n stays 1. Load wait counter with W -> ACCESS.
  - ACCESS (W+1 cycles): mem_ce_n[slot] = 0.
    - Read: mem_oe_n = 0; on the final ACCESS edge, rdata <= mem_di slice of the slot.
    - Write: mem_we_n = 0.
    - Counter decrements each cycle; at 0 -> HOLD.
  - HOLD (1 cycle): mem_oe_n = 1, mem_we_n = 1, mem_ce_n[slot] still 0; mem_a and mem_do held; ack = 1 -> IDLE.
- Latency:
  - Accepted request: ack is seen W+3 rising edges after the edge that sampled req.
  - Rejected request: ack/err are seen 1 edge after that edge.
- Strobe widths:
  - mem_ce_n low W+3 cycles.
  - mem_we_n low exactly W+1 cycles.
  - mem_oe_n low W+2 cycles.
- Only one mem_ce_n bit is low at any time. mem_oe_n and mem_we_n are never low simultaneously.
- mem_a and mem_do are stable from SETUP through HOLD.
- Handshake:
  - The host drops req in the ack cycle.
  - req still high in the IDLE cycle after ack is a new request, so back-to-back transactions have exactly one IDLE cycle between HOLD and SETUP.
  - Changes to req/we/addr/wdata outside IDLE are ignored.
- rdata is unchanged by writes and errors.
- W = 15 is legal: 16 ACCESS cycles, with no counter wrap.

Test Plan:
- Read, slot 0, W = 0, addr = 22'h000123, mem_di[7:0] = 8'hA5 -> mem_a = 20'h00123; mem_ce_n = 4'b1110 for 3 cycles; mem_oe_n low 2 cycles; ack 3 edges after req; rdata = 8'hA5; err = 0.
- Write, slot 1, WAIT_CYC[7:4] = 2, addr = 22'h100040, wdata = 8'h5A -> mem_ce_n = 4'b1101 for 5 cycles; mem_we_n low exactly 3 cycles; mem_do = 8'h5A stable throughout; ack 5 edges after req; rdata unchanged.
- Write to slot 0 (WR_MASK[0] = 0) -> no strobe toggles; ack = err = 1 for one cycle, 1 edge after req; state returns to IDLE.
- NUM_SLOTS = 3, read with addr[21:20] = 2'b11 -> ERR response; no chip enable asserted.
- req held high across two reads, slots 2 then 3 -> one IDLE cycle between the first HOLD and the second SETUP; two ack pulses; rdata updates per read.
- reset_n asserted during ACCESS of a W = 4 write -> mem_we_n/mem_ce_n go high immediately without a clock edge; ack = 0; after release, a new request completes normally.
